// File: rtl/zacore_common_pkg.sv
// Shared front-end types for the zacore pipeline: fetch/decode/execute payloads.
package zacore_common;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] pc_t;
  typedef logic [XLEN-1:0] inst_t;

  typedef struct packed {
    logic valid;
    pc_t  pc;
  } datapath_info_t;

  typedef struct packed {
    datapath_info_t datapath_info;
    inst_t          inst;
  } fetch_decode_if_t;

  typedef struct packed {
    logic  branch_taken;
    addr_t branch_target;
  } execute_fetch_if_t;

  // One prefetch buffer entry: the fetched word together with its PC.
  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Force an address onto a 4-byte instruction boundary.
  function automatic addr_t align_word(input addr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/zacore_fetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO with a separate occupancy count
// so that full and empty are distinguishable. Flush beats push and pop.
module zacore_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  // Qualify requests: a flush cancels both, and overflow/underflow are blocked.
  always_comb begin
    w_do_push = i_push & ~i_flush & (r_count != CW'(DEPTH));
    w_do_pop  = i_pop  & ~i_flush & (r_count != '0);
  end

  // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Head entry is read straight out of registered storage.
  always_comb begin
    o_data  = r_mem[r_rd_ptr];
    o_count = r_count;
  end

endmodule

// File: rtl/zacore_prefetch.sv
// Prefetch stage: owns the fetch PC and memory request, feeds fetched words
// through a small buffer to decode, and handles branch redirects and flushes.
module zacore_prefetch
  import zacore_common::*;
#(
  parameter addr_t RESET_ADDR = 32'h0000_0000,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  output logic                        o_fetch_req,
  input  logic                        i_fetch_ack,
  output logic [31:0]                 o_fetch_addr,
  input  logic [31:0]                 i_inst_read,
  output fetch_decode_if_t            o_fetch_decode_if,
  input  execute_fetch_if_t           i_execute_fetch_if,
  input  logic                        i_stall,
  input  logic                        i_invalidate,
  output logic [$clog2(FIFO_DEPTH):0] o_buf_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  pc_t          r_pc;
  logic [CW-1:0] w_count;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_valid;
  fetch_entry_t  w_wr_entry;
  fetch_entry_t  w_head;

  // Request, push/pop and flush decode; a redirect or flush suppresses the request.
  always_comb begin
    w_req      = (w_count < CW'(FIFO_DEPTH)) & ~i_execute_fetch_if.branch_taken & ~i_invalidate;
    w_push     = w_req & i_fetch_ack;
    w_valid    = (w_count != '0);
    w_pop      = w_valid & ~i_stall;
    w_flush    = i_execute_fetch_if.branch_taken | i_invalidate;
    w_wr_entry = '{pc: r_pc, inst: i_inst_read};
  end

  // Fetch PC: branch target wins, invalidate holds, an accepted fetch advances.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= RESET_ADDR;
    end else if (i_execute_fetch_if.branch_taken) begin
      r_pc <= align_word(i_execute_fetch_if.branch_target);
    end else if (i_invalidate) begin
      r_pc <= r_pc;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  zacore_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_wr_entry),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // Decode-facing outputs come from the buffer head; memory side from the PC.
  always_comb begin
    o_fetch_req                          = w_req;
    o_fetch_addr                         = r_pc;
    o_buf_count                          = w_count;
    o_fetch_decode_if.datapath_info.valid = w_valid;
    o_fetch_decode_if.datapath_info.pc    = w_head.pc;
    o_fetch_decode_if.inst                = w_head.inst;
  end

endmodule

// File: tb/tb_zacore_prefetch.sv
// Scoreboard bench for zacore_prefetch: a queue-based model of the buffer and PC
// predicts outputs; a monitor checks and retires every instruction decode consumes.
module tb_zacore_prefetch;
  import zacore_common::*;

  localparam int    DEPTH = 4;
  localparam addr_t RADDR = 32'h0000_0000;

  logic              clk;
  logic              rst;
  logic              fetch_req;
  logic              fetch_ack;
  logic [31:0]       fetch_addr;
  logic [31:0]       inst_read;
  fetch_decode_if_t  fd_if;
  execute_fetch_if_t ef_if;
  logic              stall;
  logic              inval;
  logic [2:0]        buf_count;

  int total;
  int bad;

  // Model state: expected buffer contents (pc,inst) and fetch PC.
  logic [63:0] exp_q [$];
  logic [31:0] m_pc;

  zacore_prefetch #(
    .RESET_ADDR (RADDR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .o_fetch_req        (fetch_req),
    .i_fetch_ack        (fetch_ack),
    .o_fetch_addr       (fetch_addr),
    .i_inst_read        (inst_read),
    .o_fetch_decode_if  (fd_if),
    .i_execute_fetch_if (ef_if),
    .i_stall            (stall),
    .i_invalidate       (inval),
    .o_buf_count        (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever decode sees a valid head, compare it with the oldest
  // expected entry; retire it when decode consumes and no flush is pending.
  always @(negedge clk) begin
    #2;
    if (!rst && fd_if.datapath_info.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("head_unexpected", 64'd1, 64'd0);
      end else begin
        check("head_pc",   64'(fd_if.datapath_info.pc), 64'(exp_q[0][63:32]));
        check("head_inst", 64'(fd_if.inst),             64'(exp_q[0][31:0]));
        if (!stall && !ef_if.branch_taken && !inval) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus: drive, check control outputs, then advance the model.
  task automatic cycle(input logic s, input logic a, input logic bt,
                       input logic [31:0] tgt, input logic inv);
    logic exp_req;
    @(negedge clk);
    stall     = s;
    fetch_ack = a;
    ef_if.branch_taken  = bt;
    ef_if.branch_target = tgt;
    inval     = inv;
    inst_read = $urandom;
    #1;
    exp_req = (exp_q.size() < DEPTH) && !bt && !inv;
    check("fetch_req",  64'(fetch_req),  64'(exp_req));
    check("fetch_addr", 64'(fetch_addr), 64'(m_pc));
    check("buf_count",  64'(buf_count),  64'(exp_q.size()));
    check("valid",      64'(fd_if.datapath_info.valid), 64'(exp_q.size() != 0));
    #2;
    if (bt) begin
      exp_q.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
    end else if (inv) begin
      exp_q.delete();
    end else if (exp_req && a) begin
      exp_q.push_back({m_pc, inst_read});
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    fetch_ack = 1'b0;
    inst_read = '0;
    stall = 1'b0;
    inval = 1'b0;
    ef_if = '0;
    m_pc = RADDR;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(buf_count), 64'd0);
    check("rst_valid", 64'(fd_if.datapath_info.valid), 64'd0);
    check("rst_addr",  64'(fetch_addr), 64'(RADDR));
    check("rst_req",   64'(fetch_req), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with no stall: occupancy settles at 1.
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    // Fill to full under stall, then drain in order.
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("full_count", 64'(buf_count), 64'(DEPTH));
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    // Three buffered, then redirect with an ack in the same cycle.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_1236, 1'b0);
    // Advance to 0x1240, buffer two, invalidate with ack.
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    // Branch and invalidate together: branch wins.
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b1);
    // PC wrap at the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic with rare redirects/flushes and near-wrap targets.
    for (int i = 0; i < 600; i++) begin
      logic        s, a, b, v;
      logic [31:0] t;
      s = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(s, a, b, t, v);
    end

    // Asynchronous reset between edges with the buffer full.
    repeat (DEPTH + 1) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("pre_rst_full", 64'(buf_count), 64'(DEPTH));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 64'(buf_count), 64'd0);
    check("arst_valid", 64'(fd_if.datapath_info.valid), 64'd0);
    check("arst_addr",  64'(fetch_addr), 64'(RADDR));
    exp_q.delete();
    m_pc = RADDR;
    #1;
    rst = 1'b0;
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
